// File: rtl/be_step_pulse.sv
// Debounced single-step clock pulse generator: synchronizes and debounces a step
// button and a mode switch, then issues one fixed-width pulse per accepted press.
module be_step_pulse #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 1
) (
  input  logic       iCLK,
  input  logic       RST,
  input  logic       BTN_STEP,
  input  logic       SW_SELECT,
  output logic       CLK_STEP,
  output logic       CLK_SELECT,
  output logic [7:0] STEP_COUNT
);

  // state | meaning
  // IDLE  | button released, waiting for an accepted press
  // PULSE | driving CLK_STEP high, pulse_cnt counts down the remaining width
  // HELD  | press consumed, waiting for an accepted release
  typedef enum logic [1:0] {IDLE, PULSE, HELD} state_t;

  localparam logic [23:0] DB_TC = 24'(DEBOUNCE_CYCLES);
  localparam logic [7:0]  PW_TC = 8'(PULSE_CYCLES - 1);

  logic [1:0]  btn_sync, sw_sync;
  logic [23:0] btn_cnt, sw_cnt;
  logic        btn_acc, sw_acc;
  state_t      state_q, state_d;
  logic [7:0]  pulse_cnt_q, pulse_cnt_d;
  logic [7:0]  count_q;
  logic        step_q;
  logic        start;

  // Button idles high (released), switch idles low (continuous mode).
  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      btn_sync <= 2'b11;
      sw_sync  <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], BTN_STEP};
      sw_sync  <= {sw_sync[0], SW_SELECT};
    end
  end

  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      btn_cnt <= '0;
      btn_acc <= 1'b1;
    end else if (btn_sync[1] == btn_acc) begin
      btn_cnt <= '0;
    end else if (btn_cnt == DB_TC) begin
      btn_acc <= btn_sync[1];
      btn_cnt <= '0;
    end else begin
      btn_cnt <= btn_cnt + 24'd1;
    end
  end

  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      sw_cnt <= '0;
      sw_acc <= 1'b0;
    end else if (sw_sync[1] == sw_acc) begin
      sw_cnt <= '0;
    end else if (sw_cnt == DB_TC) begin
      sw_acc <= sw_sync[1];
      sw_cnt <= '0;
    end else begin
      sw_cnt <= sw_cnt + 24'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    start       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!btn_acc) begin
          if (sw_acc) begin
            state_d     = PULSE;
            pulse_cnt_d = PW_TC;
            start       = 1'b1;
          end else begin
            state_d = HELD;
          end
        end
      end
      // Mode and button changes are ignored until the full width has been driven.
      PULSE: begin
        if (pulse_cnt_q == 8'd0) state_d = btn_acc ? IDLE : HELD;
        else                     pulse_cnt_d = pulse_cnt_q - 8'd1;
      end
      HELD: begin
        if (btn_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      count_q     <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      count_q     <= count_q + {7'd0, start};
      step_q      <= (state_d == PULSE);
    end
  end

  assign CLK_STEP   = step_q;
  assign CLK_SELECT = sw_acc;
  assign STEP_COUNT = count_q;

endmodule

// File: tb/tb_be_step_pulse.sv
// Bench for be_step_pulse: directed scenarios plus random bouncing, each cycle
// checked against a windowed debounce / pulse-event reference model.
module tb_be_step_pulse;
  localparam int D = 4;
  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst, btn, sw;
  logic       clk_step, clk_select;
  logic [7:0] step_count;

  int checks = 0;
  int errors = 0;

  be_step_pulse #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
    .iCLK(clk), .RST(rst), .BTN_STEP(btn), .SW_SELECT(sw),
    .CLK_STEP(clk_step), .CLK_SELECT(clk_select), .STEP_COUNT(step_count)
  );

  always #5 clk = ~clk;

  // Reference model: raw-sample histories (index 0 = newest edge), accepted levels,
  // and pulse bookkeeping expressed as press events.
  bit q_btn[$];
  bit q_sw[$];
  bit m_btn_acc, m_sw_acc, m_consumed, m_step;
  int m_left, m_count;

  function automatic void model_reset();
    q_btn.delete();
    q_sw.delete();
    for (int i = 0; i < D + 3; i++) begin
      q_btn.push_back(1'b1);
      q_sw.push_back(1'b0);
    end
    m_btn_acc = 1'b1; m_sw_acc = 1'b0; m_consumed = 1'b0;
    m_step = 1'b0; m_left = 0; m_count = 0;
  endfunction

  // Level flips when the synchronized view (raw delayed two edges) has disagreed
  // with the accepted level for D+1 consecutive edges.
  function automatic bit flips(input bit q[$], input bit acc);
    for (int j = 2; j <= 2 + D; j++)
      if (q[j] == acc) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_edge();
    bit pb, ps;
    q_btn.push_front(btn); void'(q_btn.pop_back());
    q_sw.push_front(sw);   void'(q_sw.pop_back());
    pb = m_btn_acc;
    ps = m_sw_acc;
    if (m_left > 0) begin
      m_step = 1'b1;
      m_left--;
    end else begin
      m_step = 1'b0;
      if (!m_consumed && !pb) begin
        m_consumed = 1'b1;
        if (ps) begin
          m_step  = 1'b1;
          m_left  = P - 1;
          m_count = (m_count + 1) % 256;
        end
      end else if (pb) begin
        m_consumed = 1'b0;
      end
    end
    if (flips(q_btn, m_btn_acc)) m_btn_acc = ~m_btn_acc;
    if (flips(q_sw, m_sw_acc))   m_sw_acc  = ~m_sw_acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    chk("clk_step", {31'd0, clk_step}, {31'd0, m_step});
    chk("clk_select", {31'd0, clk_select}, {31'd0, m_sw_acc});
    chk("step_count", {24'd0, step_count}, m_count);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Runs n edges from "now"; edge 0 is the first one. Reports first high edge and high count.
  task automatic watch(input int n, output int first, output int highs);
    first = -1;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (clk_step) begin
        if (first < 0) first = i;
        highs++;
      end
    end
  endtask

  initial begin
    int first, highs, base_cnt, bounce_highs;
    rst = 1'b0; btn = 1'b1; sw = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("reset_step", {31'd0, clk_step}, 32'd0);
    chk("reset_select", {31'd0, clk_select}, 32'd0);
    chk("reset_count", {24'd0, step_count}, 32'd0);
    run(2);
    rst = 1'b0;

    // Quiet inputs give no activity.
    watch(20, first, highs);
    chk("quiet_highs", highs, 32'd0);

    // Clean press in manual mode: pulse on edges 7-8.
    sw = 1'b1;
    run(12);
    btn = 1'b0;
    watch(16, first, highs);
    chk("clean_first", first, 32'd7);
    chk("clean_width", highs, 32'd2);
    chk("clean_count", {24'd0, step_count}, 32'd1);
    btn = 1'b1;
    run(12);

    // Bounce every 2 cycles for 20 cycles, then settle low.
    bounce_highs = 0;
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (clk_step) bounce_highs++;
    end
    chk("bounce_highs", bounce_highs, 32'd0);
    btn = 1'b0;
    watch(16, first, highs);
    chk("bounce_first", first, 32'd7);
    chk("bounce_width", highs, 32'd2);
    btn = 1'b1;
    run(12);

    // Continuous mode: press/release gives nothing; mode change while held gives nothing.
    sw = 1'b0;
    run(10);
    base_cnt = step_count;
    btn = 1'b0; run(12);
    btn = 1'b1; run(12);
    btn = 1'b0; run(12);
    sw = 1'b1;
    watch(14, first, highs);
    chk("held_sel_change_highs", highs, 32'd0);
    chk("held_sel_change_count", {24'd0, step_count}, base_cnt);
    btn = 1'b1; run(12);
    btn = 1'b0;
    watch(12, first, highs);
    chk("new_press_width", highs, 32'd2);
    btn = 1'b1; run(12);

    // 256 clean presses wrap the counter back to its start value.
    base_cnt = step_count;
    for (int i = 0; i < 256; i++) begin
      btn = 1'b0; run(10);
      btn = 1'b1; run(10);
    end
    chk("wrap_count", {24'd0, step_count}, base_cnt);

    // Random bouncing on both inputs, followed by random stable periods.
    for (int it = 0; it < 60; it++) begin
      int bursts;
      bursts = $urandom_range(0, 6);
      for (int b = 0; b < bursts; b++) begin
        btn = $urandom_range(0, 1);
        if ($urandom_range(0, 3) == 0) sw = $urandom_range(0, 1);
        run($urandom_range(1, 3));
      end
      btn = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) sw = $urandom_range(0, 1);
      run($urandom_range(1, 16));
    end

    // Reset mid-pulse with the button still held.
    btn = 1'b1; sw = 1'b1;
    run(14);
    btn = 1'b0;
    for (int i = 0; i < 20 && !clk_step; i++) tick();
    chk("pulse_seen", {31'd0, clk_step}, 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_step", {31'd0, clk_step}, 32'd0);
    chk("async_rst_select", {31'd0, clk_select}, 32'd0);
    chk("async_rst_count", {24'd0, step_count}, 32'd0);
    run(3);
    rst = 1'b0;
    watch(16, first, highs);
    chk("post_rst_first", first, 32'd7);
    chk("post_rst_width", highs, 32'd2);
    chk("post_rst_count", {24'd0, step_count}, 32'd1);
    btn = 1'b1;
    run(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
